// File: rtl/tdc_thermo_accum.sv
// tdc_thermo_accum: bubble-filters and decodes TDC thermometer codes, then
// accumulates a programmable number of samples into sum, min and max.
//
// Ports:
//   clock, reset          block clock, asynchronous active-high reset
//   tdc_dout, tdc_valid   thermometer code (bit 0 = least-delayed tap) and strobe
//   start                 begins a measurement (honoured in IDLE only)
//   busy                  high while collecting samples
//   sample_valid/value    per-sample decoded leading-ones count
//   result_valid/ready    completed measurement handshake
//   result_sum/min/max    accumulated statistics
//   overrange             sticky: an accumulated sample was all ones
//
// Build option: define TDC_MINMAX_EN to build the min/max trackers; otherwise
// result_min and result_max are tied to zero.
module tdc_thermo_accum #(
    parameter int DATA_WIDTH   = 252,
    parameter int LOG2_SAMPLES = 4,
    localparam int PW          = $clog2(DATA_WIDTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      tdc_dout,
    input  logic                       tdc_valid,
    input  logic                       start,
    output logic                       busy,
    output logic                       sample_valid,
    output logic [PW-1:0]              sample_value,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [PW+LOG2_SAMPLES-1:0] result_sum,
    output logic [PW-1:0]              result_min,
    output logic [PW-1:0]              result_max,
    output logic                       overrange
);
    localparam int SW = PW + LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES:0] LAST = (LOG2_SAMPLES + 1)'((2 ** LOG2_SAMPLES) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;

    logic [DATA_WIDTH+1:0] pad;
    logic [DATA_WIDTH-1:0] filt, m;
    logic [PW-1:0]         lead;
    logic                  v1, t1, t2, acc, last;
    logic [LOG2_SAMPLES:0] cnt;
    logic [SW-1:0]         sum;

    // Boundary taps: below bit 0 reads as one, above the top reads as zero.
    assign pad  = {1'b0, tdc_dout, 1'b1};
    assign filt = (pad[DATA_WIDTH-1:0] & pad[DATA_WIDTH:1])
                | (pad[DATA_WIDTH-1:0] & pad[DATA_WIDTH+1:2])
                | (pad[DATA_WIDTH:1]   & pad[DATA_WIDTH+1:2]);

    // Position of the lowest zero; ones above it are ignored.
    always_comb begin
        lead = PW'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            if (!m[i]) lead = PW'(i);
    end

    // t1/t2 tag samples captured while busy, so codes arriving before the
    // measurement started never count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m            <= '0;
            v1           <= 1'b0;
            t1           <= 1'b0;
            t2           <= 1'b0;
            sample_valid <= 1'b0;
            sample_value <= '0;
        end else begin
            v1           <= tdc_valid;
            t1           <= tdc_valid && state == RUN;
            t2           <= t1;
            sample_valid <= v1;
            if (tdc_valid) m <= filt;
            if (v1) sample_value <= lead;
        end
    end

    assign acc  = sample_valid && t2 && state == RUN;
    assign last = acc && cnt == LAST;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = (state == IDLE && start)        ? RUN  :
               (state == RUN  && last)         ? DONE :
               (state == DONE && result_ready) ? IDLE : state;
    end

    always_comb begin
        busy         = state == RUN;
        result_valid = state == DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum       <= '0;
            cnt       <= '0;
            overrange <= 1'b0;
        end else if (state == IDLE && start) begin
            sum       <= '0;
            cnt       <= '0;
            overrange <= 1'b0;
        end else if (acc) begin
            sum       <= sum + SW'(sample_value);
            cnt       <= cnt + 1'b1;
            overrange <= overrange | (sample_value == PW'(DATA_WIDTH));
        end
    end

    assign result_sum = sum;

`ifdef TDC_MINMAX_EN
    logic [PW-1:0] min_q, max_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (state == IDLE && start) begin
            min_q <= '1;
            max_q <= '0;
        end else if (acc) begin
            min_q <= sample_value < min_q ? sample_value : min_q;
            max_q <= sample_value > max_q ? sample_value : max_q;
        end
    end

    assign result_min = min_q;
    assign result_max = max_q;
`else
    assign result_min = '0;
    assign result_max = '0;
`endif

endmodule

// File: tb/tb_tdc_thermo_accum.sv
// tb_tdc_thermo_accum: directed self-checking bench with a sample scoreboard.
module tb_tdc_thermo_accum;
    localparam int DW = 252;
    localparam int L  = 4;
    localparam int PW = 8;

`ifdef TDC_MINMAX_EN
    localparam logic [31:0] MIN_RST = 32'd255;
    function automatic logic [31:0] mm(input int v); return v; endfunction
`else
    localparam logic [31:0] MIN_RST = 32'd0;
    function automatic logic [31:0] mm(input int v); return 0; endfunction
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] tdc_dout = '0;
    logic          tdc_valid = 1'b0;
    logic          start = 1'b0;
    logic          result_ready = 1'b0;
    logic          busy, sample_valid, result_valid, overrange;
    logic [PW-1:0] sample_value, result_min, result_max;
    logic [PW+L-1:0] result_sum;

    int errors = 0;
    int checks = 0;
    int q[$];

    tdc_thermo_accum #(.DATA_WIDTH(DW), .LOG2_SAMPLES(L)) dut (
        .clock(clock), .reset(reset), .tdc_dout(tdc_dout), .tdc_valid(tdc_valid),
        .start(start), .busy(busy), .sample_valid(sample_valid),
        .sample_value(sample_value), .result_valid(result_valid),
        .result_ready(result_ready), .result_sum(result_sum),
        .result_min(result_min), .result_max(result_max), .overrange(overrange)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every decoded sample is matched against what was driven.
    always @(negedge clock) begin
        if (sample_valid) begin
            if (q.size() == 0) chk("sb_underflow", q.size(), 1);
            else chk("sample", sample_value, q.pop_front());
        end
    end

    function automatic logic [DW-1:0] ones(input int k);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < k; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int k);
        tdc_dout  = ones(k);
        tdc_valid = 1'b1;
        q.push_back(k);
        cyc();
    endtask

    task automatic idle(input int n);
        tdc_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wait_result(input int maxc);
        int n = 0;
        while (!result_valid && n < maxc) begin
            cyc();
            n++;
        end
        chk("result_timeout", result_valid, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sv"}, sample_valid, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_ovr"}, overrange, 0);
        chk({tag, "_val"}, sample_value, 0);
        chk({tag, "_sum"}, result_sum, 0);
        chk({tag, "_max"}, result_max, 0);
        chk({tag, "_min"}, result_min, MIN_RST);
    endtask

    initial begin
        logic [DW-1:0] b;
        repeat (3) cyc();
        check_reset_values("rst");
        reset = 1'b0;
        cyc();

        // Single sample outside RUN: decoded, never accumulated.
        drive(100);
        tdc_valid = 1'b0;
        cyc();
        chk("lat_sv", sample_valid, 1);
        chk("lat_val", sample_value, 100);
        idle(2);
        chk("idle_rv", result_valid, 0);
        chk("idle_sum", result_sum, 0);

        // 16 back-to-back samples of 50.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_on", busy, 1);
        for (int i = 0; i < 16; i++) drive(50);
        tdc_valid = 1'b0;
        cyc();
        chk("rv_early", result_valid, 0);
        cyc();
        chk("rv_on", result_valid, 1);
        chk("busy_off", busy, 0);
        chk("sum800", result_sum, 800);
        chk("min50", result_min, mm(50));
        chk("max50", result_max, mm(50));
        chk("ovr0", overrange, 0);
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("accept_rv", result_valid, 0);
        chk("persist_sum", result_sum, 800);

        // Bubble at bit 30 and stray one at bit 80 are filtered out.
        b = ones(60);
        b[30] = 1'b0;
        b[80] = 1'b1;
        tdc_dout  = b;
        tdc_valid = 1'b1;
        q.push_back(60);
        cyc();
        idle(3);

        // Boundary samples: zero and all ones.
        start = 1'b1;
        cyc();
        start = 1'b0;
        drive(0);
        drive(252);
        drive(17);
        for (int i = 0; i < 13; i++) drive(10);
        tdc_valid = 1'b0;
        wait_result(6);
        chk("sum399", result_sum, 399);
        chk("min0", result_min, mm(0));
        chk("max252", result_max, mm(252));
        chk("ovr1", overrange, 1);

        // DONE holds while result_ready is low; extra samples and start ignored.
        for (int i = 0; i < 20; i++) begin
            start = (i == 7);
            drive(5);
        end
        start = 1'b0;
        idle(3);
        chk("hold_rv", result_valid, 1);
        chk("hold_busy", busy, 0);
        chk("hold_sum", result_sum, 399);
        chk("hold_min", result_min, mm(0));
        chk("hold_max", result_max, mm(252));
        chk("hold_ovr", overrange, 1);
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        chk("acc2_rv", result_valid, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_sum", result_sum, 0);
        chk("restart_ovr", overrange, 0);
        chk("restart_min", result_min, MIN_RST);
        chk("restart_max", result_max, 0);

        // Reset mid-measurement with a sample still in the pipeline.
        for (int i = 0; i < 7; i++) drive(20);
        idle(3);
        chk("partial_sum", result_sum, 140);
        drive(33);
        tdc_valid = 1'b0;
        reset = 1'b1;
        q.delete();
        #1;
        check_reset_values("midrst");
        cyc();
        reset = 1'b0;
        cyc();
        chk("midrst_sv", sample_valid, 0);

        // Clean measurement after reset.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) drive(3 * i);
        tdc_valid = 1'b0;
        wait_result(6);
        chk("sum360", result_sum, 360);
        chk("min_clean", result_min, mm(0));
        chk("max45", result_max, mm(45));
        chk("ovr_clean", overrange, 0);
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        idle(3);
        chk("sb_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdc_thermo_accum.md
# tdc_thermo_accum

Downstream consumer of the 252-bit TDC thermometer word. It bubble-filters each captured code and decodes it to a leading-ones count, i.e. a delay in TDC unit cells. It then accumulates a programmable number of samples into a sum, min and max for the SRAM BIST timing readout. Sits between the TDC capture register and the BIST MMIO/scan result registers.

## Interface
Parameters:
- DATA_WIDTH, 252, thermometer code width from the TDC.
- LOG2_SAMPLES, 4, log2 of samples per measurement (1..8).
- PW (localparam), clog2(DATA_WIDTH+1) = 8, decoded sample width.

Ports:
- clock  in  1  single block clock.
- reset  in  1  asynchronous, active-high reset.
- tdc_dout  in  DATA_WIDTH  thermometer code; bit 0 is the least-delayed tap.
- tdc_valid  in  1  one-cycle strobe; tdc_dout is stable and synchronous to clock in this cycle.
- start  in  1  one-cycle pulse; begins a measurement.
- busy  out  1  high in RUN.
- sample_valid  out  1  per-sample decode strobe.
- sample_value  out  PW  last decoded sample.
- result_valid  out  1  measurement complete; held until accepted.
- result_ready  in  1  consumer accepts the result.
- result_sum  out  PW+LOG2_SAMPLES  sum of samples.
- result_min  out  PW  minimum sample.
- result_max  out  PW  maximum sample.
- overrange  out  1  sticky flag: some accumulated sample had all ones.

## Operation
- Stage 1 (capture): on tdc_valid, register the filtered code m.
  - m[i] = majority(c[i-1], c[i], c[i+1]), with c[-1]=1 and c[DATA_WIDTH]=0.
- Stage 2 (decode): sample_value = number of consecutive ones in m starting at bit 0, range 0..DATA_WIDTH.
  - Ones above the first zero are ignored.
  - sample_valid pulses for one cycle.
- FSM states IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. Entry clears sum to 0, min to all-ones (2^PW-1), max to 0, sample counter to 0 and overrange.
  - RUN: each sample_valid adds sample_value to sum, updates min/max and increments the counter. The accumulate that brings the counter to 2^LOG2_SAMPLES moves to DONE in the same edge.
  - DONE: result_valid=1 and outputs are frozen. result_valid && result_ready -> IDLE. Results persist in IDLE until the next start.
- start in RUN or DONE: ignored.
- sample_valid in IDLE or DONE: sample_value still updates, nothing is accumulated.
- Samples in flight when DONE is entered are dropped.
- Sum width PW+LOG2_SAMPLES cannot overflow. No saturation logic.
- sample_value == DATA_WIDTH (all ones) is accumulated as is and sets overrange (sticky until the next start).
- Code of all zeros decodes to 0.

## Timing
- Reset values:
  - FSM=IDLE; busy, sample_valid, result_valid, overrange = 0.
  - sample_value, result_sum, result_max = 0; result_min = 2^PW-1.
- Latency: tdc_valid at edge N -> sample_valid/sample_value at N+2 -> accumulated at N+3.
- Throughput: one sample per cycle. Back-to-back tdc_valid is fully supported.
- start -> busy high the next cycle. The first countable tdc_valid is the one coincident with busy=1 or later.
- Last sample accumulated at edge K -> result_valid at K (registered, visible in cycle K+1); busy drops at the same edge.
- result_ready may be held high in advance. Acceptance takes one cycle, and start is honoured in the cycle after return to IDLE.
- Reset asserted mid-measurement: immediately returns to reset values. In-flight pipeline data is discarded.

## Configuration
- TDC_MINMAX_EN defined: min/max trackers are built as described.
- Not defined: no min/max registers. result_min and result_max are tied to 0 at all times. Sum, count and overrange are unchanged.

## Test plan
- Reset, then a single sample outside RUN (tdc_dout = 100 ones from bit 0): sample_value=100 two cycles after tdc_valid; result_valid stays 0 and no accumulation.
- start, then 16 back-to-back codes of 50 ones each: result_sum=800, min=max=50, result_valid one cycle after the 16th accumulate, busy=0.
- Bubble code: ones at bits 0..59 with bit 30 cleared, plus a stray one at bit 80 -> sample_value=60. Without the filter the value would have been 30.
- Samples 0, 252, 17, then 13×10 codes: sum=399, min=0, max=252, overrange=1. With TDC_MINMAX_EN undefined: min=max=0, sum unchanged.
- result_ready held low for 20 cycles in DONE: outputs frozen and extra tdc_valid ignored. Then result_ready=1 -> IDLE, and start the next cycle clears the sum.
- reset pulsed after 7 samples in RUN: all outputs return to reset values, and the following start gives a clean 16-sample result.
